// File: rtl/freq_meter_if.sv
// rtl/freq_meter_if.sv - measured-signal input and frequency-code result bundle for freq_meter
interface freq_meter_if;
    logic       sig_in;
    logic [7:0] freq_param;
    logic       valid;
    logic       update;
    logic       under_range;
    logic       over_range;
    logic       no_signal;

    modport master (
        input  sig_in,
        output freq_param, valid, update, under_range, over_range, no_signal
    );

    modport slave (
        output sig_in,
        input  freq_param, valid, update, under_range, over_range, no_signal
    );
endinterface

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - period-counting frequency meter with shared sequential divider; FREQ_METER_AVG_EN enables 4-interval averaging
module freq_meter #(
    parameter int F_REF          = 50000000,
    parameter int F_CLK_MIN      = 6000,
    parameter int F_CLK_MAX      = 800000,
    parameter int MIN_CLK_STEP   = (F_CLK_MAX - F_CLK_MIN) / 255,
    parameter int TIMEOUT_CYCLES = 16667
) (
    input  logic         clk_in,
    input  logic         reset,
    freq_meter_if.master mif
);

`ifdef FREQ_METER_AVG_EN
    localparam int          PW       = 18;
    localparam logic [31:0] DIVIDEND = 32'(4 * F_REF);
`else
    localparam int          PW       = 16;
    localparam logic [31:0] DIVIDEND = 32'(F_REF);
`endif

    typedef enum logic [2:0] {IDLE, DIV_F, SUB, DIV_CODE, WRITE} state_t;

    state_t          state;
    logic [2:0]      sync;
    logic            rise;
    logic [15:0]     cnt;
    logic            armed;
    logic [PW-1:0]   pend;
    logic            pend_valid;
    logic [PW-1:0]   new_period;
    logic            new_valid;
    logic            tmo;
`ifdef FREQ_METER_AVG_EN
    logic [PW-1:0]   acc;
    logic [1:0]      avg_cnt;
`endif

    logic [31:0]     quo;
    logic [31:0]     rem;
    logic [31:0]     dvs;
    logic [4:0]      bit_cnt;
    logic [32:0]     rem_sh;
    logic [32:0]     rem_diff;
    logic            r_under;

    logic [7:0]      freq_param_r;
    logic            valid_r, update_r, under_r, over_r, no_signal_r;

    assign rise = sync[1] & ~sync[2];
    assign tmo  = armed && !rise && (cnt == 16'(TIMEOUT_CYCLES));

    // A completed interval (or group of four) is only offered when the meter is locked
    always_comb begin
        new_valid  = 1'b0;
        new_period = '0;
`ifdef FREQ_METER_AVG_EN
        if (rise && armed && avg_cnt == 2'd3) begin
            new_period = acc + PW'(cnt);
            new_valid  = (new_period >= PW'(2));
        end
`else
        if (rise && armed) begin
            new_period = cnt;
            new_valid  = (new_period >= PW'(2));
        end
`endif
    end

    // One restoring step: remainder absorbs the next dividend bit, quotient bit shifts in
    always_comb begin
        rem_sh   = {rem, quo[31]};
        rem_diff = rem_sh - {1'b0, dvs};
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= IDLE;
            sync         <= '0;
            cnt          <= '0;
            armed        <= 1'b0;
            pend         <= '0;
            pend_valid   <= 1'b0;
            quo          <= '0;
            rem          <= '0;
            dvs          <= '0;
            bit_cnt      <= '0;
            r_under      <= 1'b0;
            freq_param_r <= '0;
            valid_r      <= 1'b0;
            update_r     <= 1'b0;
            under_r      <= 1'b0;
            over_r       <= 1'b0;
            no_signal_r  <= 1'b0;
`ifdef FREQ_METER_AVG_EN
            acc          <= '0;
            avg_cnt      <= '0;
`endif
        end else begin
            sync     <= {sync[1:0], mif.sig_in};
            update_r <= 1'b0;

            if (rise)
                cnt <= 16'd1;
            else if (cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;

            if (tmo) begin
                no_signal_r <= 1'b1;
                valid_r     <= 1'b0;
                armed       <= 1'b0;
                pend_valid  <= 1'b0;
                state       <= IDLE;
`ifdef FREQ_METER_AVG_EN
                acc         <= '0;
                avg_cnt     <= '0;
`endif
            end else begin
                if (rise)
                    armed <= 1'b1;
`ifdef FREQ_METER_AVG_EN
                if (rise) begin
                    if (!armed || avg_cnt == 2'd3) begin
                        acc     <= '0;
                        avg_cnt <= '0;
                    end else begin
                        acc     <= acc + PW'(cnt);
                        avg_cnt <= avg_cnt + 2'd1;
                    end
                end
`endif
                case (state)
                    IDLE: begin
                        if (pend_valid || new_valid) begin
                            quo        <= DIVIDEND;
                            rem        <= '0;
                            bit_cnt    <= '0;
                            dvs        <= 32'(pend_valid ? pend : new_period);
                            state      <= DIV_F;
                            pend_valid <= pend_valid & new_valid;
                            if (new_valid)
                                pend <= new_period;
                        end
                    end
                    DIV_F, DIV_CODE: begin
                        if (!rem_diff[32]) begin
                            rem <= rem_diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= rem_sh[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31)
                            state <= (state == DIV_F) ? SUB : WRITE;
                    end
                    SUB: begin
                        if (quo < 32'(F_CLK_MIN)) begin
                            r_under <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            r_under <= 1'b0;
                            quo     <= quo - 32'(F_CLK_MIN) + 32'(MIN_CLK_STEP / 2);
                            dvs     <= 32'(MIN_CLK_STEP);
                            rem     <= '0;
                            bit_cnt <= '0;
                            state   <= DIV_CODE;
                        end
                    end
                    WRITE: begin
                        under_r     <= r_under;
                        over_r      <= !r_under && (quo > 32'd255);
                        if (r_under)
                            freq_param_r <= 8'd0;
                        else if (quo > 32'd255)
                            freq_param_r <= 8'd255;
                        else
                            freq_param_r <= quo[7:0];
                        valid_r     <= 1'b1;
                        update_r    <= 1'b1;
                        no_signal_r <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase

                // Edges arriving mid-conversion park here; the newest one wins
                if (state != IDLE && new_valid) begin
                    pend       <= new_period;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    assign mif.freq_param  = freq_param_r;
    assign mif.valid       = valid_r;
    assign mif.update      = update_r;
    assign mif.under_range = under_r;
    assign mif.over_range  = over_r;
    assign mif.no_signal   = no_signal_r;

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter F_REF, default 50000000, clk_in frequency in Hz.
REQ-002 Parameter F_CLK_MIN, default 6000, frequency in Hz mapped to code 0.
REQ-003 Parameter F_CLK_MAX, default 800000, upper frequency in Hz of the code range.
REQ-004 Parameter MIN_CLK_STEP, default (F_CLK_MAX-F_CLK_MIN)/255 (integer, 3113), Hz per code step.
REQ-005 Parameter TIMEOUT_CYCLES, default 16667, clk_in cycles without a sig_in rising edge before no_signal.
REQ-006 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 sig_in  input  1  asynchronous square wave to measure.
REQ-009 freq_param  output  8  measured frequency code; f = MIN_CLK_STEP*code + F_CLK_MIN.
REQ-010 valid  output  1  freq_param holds a conversion of the current signal.
REQ-011 update  output  1  one-cycle pulse when freq_param is written.
REQ-012 under_range  output  1  last conversion had f < F_CLK_MIN.
REQ-013 over_range  output  1  last conversion had computed code > 255.
REQ-014 no_signal  output  1  no rising edge for TIMEOUT_CYCLES cycles.

Function
REQ-015 sig_in SHALL pass a 2-flop synchronizer; rising edge detected on synchronized 0->1, one cycle later.
REQ-016 A 16-bit period counter SHALL count clk_in cycles between detected edges, saturating at 65535; on an edge the count (including that cycle) is latched as the period and the counter restarts at 1.
REQ-017 The first edge after reset or after no_signal SHALL only start counting; no period is latched.
REQ-018 Conversion: f = floor(F_REF/period); if f < F_CLK_MIN then code = 0, under_range = 1; else code = floor((f - F_CLK_MIN + MIN_CLK_STEP/2)/MIN_CLK_STEP), clamped to 255 with over_range = 1.
REQ-019 Both divisions SHALL use one shared 32-bit sequential restoring divider (1 quotient bit per cycle); no combinational divide.
REQ-020 FSM states IDLE, DIV_F, SUB, DIV_CODE, WRITE; IDLE->DIV_F on latched period, DIV_F->SUB after 32 cycles, SUB->WRITE if under_range else DIV_CODE, DIV_CODE->WRITE after 32 cycles, WRITE->IDLE.
REQ-021 In WRITE: freq_param, under_range, over_range updated; valid = 1; update pulses one cycle; no_signal = 0.
REQ-022 Latency from detected edge to update SHALL be at most 72 clk_in cycles.
REQ-023 Edge while FSM not IDLE: period stored in a one-deep pending register (newest overwrites); conversion starts from pending in the cycle after WRITE.
REQ-024 Counter reaching TIMEOUT_CYCLES: no_signal = 1, valid = 0, freq_param/range flags hold, pending cleared; an in-flight conversion is discarded (no update).
REQ-025 Period of 0 or 1 SHALL never reach the divider; minimum latched period is 2.

Reset
REQ-026 reset SHALL force freq_param = 0, valid = 0, update = 0, under_range = 0, over_range = 0, no_signal = 0, FSM = IDLE, counter = 0, pending empty, synchronizer = 0.
REQ-027 reset mid-conversion SHALL abort it with no update pulse.

Configuration
REQ-028 Macro FREQ_METER_AVG_EN defined: period = sum of 4 consecutive edge intervals (18-bit) and dividend = 4*F_REF; one conversion per 4 intervals; timeout still per interval.
REQ-029 FREQ_METER_AVG_EN undefined: single-interval period, dividend F_REF, as REQ-016..018.

Verification
REQ-030 Period 8333 cycles -> f=6000, freq_param=0, valid=1, both range flags 0.
REQ-031 Period 100 cycles -> f=500000, freq_param=159, update once per edge, latency <= 72 cycles.
REQ-032 Period 63 cycles (busy overlap) -> freq_param=253, pending path exercised, no lost lock-up.
REQ-033 Period 10000 -> freq_param=0, under_range=1; period 50 -> freq_param=255, over_range=1.
REQ-034 Stop sig_in after valid -> no_signal=1, valid=0 exactly TIMEOUT_CYCLES after last edge, freq_param held; resume -> valid after second edge.
REQ-035 reset asserted during DIV_CODE -> all outputs at reset values next cycle, no update pulse.
